mips_cpu_wb_queue: RTL

Writeback queue sitting in front of the register file's single write port. Accepts completed results from two producers (load unit and ALU), buffers them in order, and drains one result per cycle onto the register file's `write_index`/`write_enable`/`write_data` inputs. Keeps a pending-destination scoreboard so decode can stall on RAW hazards. Optionally forwards pending data to decode.

---
 rtl/mips_cpu_wb_queue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_wb_queue.sv
// mips_cpu_wb_queue
//
// Writeback queue in front of the register file's single write port. Results from the load
// unit (mem_*) and the ALU (alu_*) are buffered in acceptance order and drained one per cycle
// through a registered output stage onto write_index/write_enable/write_data. A pending-
// destination scoreboard (busy_rs/busy_rt) lets decode stall on RAW hazards.
//
// Optional feature: define MIPS_CPU_WB_QUEUE_FWD_EN to add fwd_rs_*/fwd_rt_* ports, which return
// the youngest pending data for the queried register.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   mem_valid/index/data     load result in; mem_ready out
//   alu_valid/index/data     ALU result in; alu_ready out
//   write_index/enable/data  register file write port
//   query_rs, query_rt       decode source indices
//   busy_rs, busy_rt         a pending write targets the queried index
//   count                    occupied queue entries (output register excluded)
//   fwd_r{s,t}_valid/data    forwarding hit and data (only with MIPS_CPU_WB_QUEUE_FWD_EN)

module mips_cpu_wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid,
    input  logic [4:0]              mem_index,
    input  logic [31:0]             mem_data,
    output logic                    mem_ready,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_index,
    input  logic [31:0]             alu_data,
    output logic                    alu_ready,
    output logic [4:0]              write_index,
    output logic                    write_enable,
    output logic [31:0]             write_data,
    input  logic [4:0]              query_rs,
    input  logic [4:0]              query_rt,
    output logic                    busy_rs,
    output logic                    busy_rt,
`ifdef MIPS_CPU_WB_QUEUE_FWD_EN
    output logic                    fwd_rs_valid,
    output logic                    fwd_rt_valid,
    output logic [31:0]             fwd_rs_data,
    output logic [31:0]             fwd_rt_data,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ.
    logic [CntW-1:0]  head_q, head_d;
    logic [CntW-1:0]  tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       idx_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic             out_valid_q;
    logic [4:0]       out_index_q;
    logic [31:0]      out_data_q;

    logic [CntW-1:0]  free;
    logic             mem_push;
    logic             alu_push;
    logic             pop;
    logic [PtrW-1:0]  head_slot;
    logic [PtrW-1:0]  mem_slot;
    logic [PtrW-1:0]  alu_slot;

    // ------------------------------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------------------------------
    assign count = tail_q - head_q;
    assign free  = DepthCnt - count;

    // Readies look only at the occupancy before this edge; the same-cycle pop is ignored so the
    // ready paths stay short. The ALU gives way to the load unit when only one slot is left.
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CntW'(2)) || ((free != '0) && !mem_valid);

    // Writes to r0 complete the handshake but are dropped here.
    assign mem_push = mem_valid && mem_ready && (mem_index != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_index != 5'd0);
    assign pop      = (count != '0);

    assign head_slot = head_q[PtrW-1:0];
    assign mem_slot  = tail_q[PtrW-1:0];
    // The load entry is placed ahead of the ALU entry when both arrive together.
    assign alu_slot  = tail_q[PtrW-1:0] + PtrW'(mem_push);

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_slot] = 1'b0;
        end
        if (mem_push) begin
            valid_d[mem_slot] = 1'b1;
        end
        if (alu_push) begin
            valid_d[alu_slot] = 1'b1;
        end
        head_d = head_q + CntW'(pop);
        tail_d = tail_q + CntW'(mem_push) + CntW'(alu_push);
    end

    // ------------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= 5'd0;
            out_data_q  <= 32'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            out_valid_q <= pop;
            if (pop) begin
                out_index_q <= idx_q[head_slot];
                out_data_q  <= data_q[head_slot];
            end
        end
    end

    // Payload storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            idx_q[mem_slot]  <= mem_index;
            data_q[mem_slot] <= mem_data;
        end
        if (alu_push) begin
            idx_q[alu_slot]  <= alu_index;
            data_q[alu_slot] <= alu_data;
        end
    end

    assign write_enable = out_valid_q;
    assign write_index  = out_index_q;
    assign write_data   = out_data_q;

    // ------------------------------------------------------------------------------------------
    // Pending-destination scoreboard
    // ------------------------------------------------------------------------------------------
    always_comb begin
        busy_rs = out_valid_q && (out_index_q == query_rs);
        busy_rt = out_valid_q && (out_index_q == query_rt);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (idx_q[i] == query_rs)) begin
                busy_rs = 1'b1;
            end
            if (valid_q[i] && (idx_q[i] == query_rt)) begin
                busy_rt = 1'b1;
            end
        end
        if (query_rs == 5'd0) begin
            busy_rs = 1'b0;
        end
        if (query_rt == 5'd0) begin
            busy_rt = 1'b0;
        end
    end

`ifdef MIPS_CPU_WB_QUEUE_FWD_EN
    // ------------------------------------------------------------------------------------------
    // Forwarding: walk entries oldest to newest so the youngest match wins; the output
    // register is older than every queued entry and has lowest priority.
    // ------------------------------------------------------------------------------------------
    logic [PtrW-1:0] fwd_slot;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;

    always_comb begin
        fwd_slot = '0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        if (out_valid_q && (out_index_q == query_rs)) begin
            rs_data = out_data_q;
        end
        if (out_valid_q && (out_index_q == query_rt)) begin
            rt_data = out_data_q;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            fwd_slot = head_slot + PtrW'(k);
            if (valid_q[fwd_slot] && (idx_q[fwd_slot] == query_rs)) begin
                rs_data = data_q[fwd_slot];
            end
            if (valid_q[fwd_slot] && (idx_q[fwd_slot] == query_rt)) begin
                rt_data = data_q[fwd_slot];
            end
        end
    end

    assign fwd_rs_valid = busy_rs;
    assign fwd_rt_valid = busy_rt;
    assign fwd_rs_data  = busy_rs ? rs_data : 32'd0;
    assign fwd_rt_data  = busy_rt ? rt_data : 32'd0;
`endif

endmodule
